// File: rtl/pc_unit_ras_if.sv
// Next-PC request / fetch-address bundle between the control unit (master)
// and the program-counter unit with return-address stack (slave).
interface pc_unit_ras_if #(
   parameter int WIDTH     = 16,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic             stall;
   logic             branch_en;
   logic             call_en;
   logic             ret_en;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus;
   logic [CNT_W-1:0] ras_count;
   logic             ras_full;
   logic             ras_empty;
   logic             ras_ovf;
   logic             ras_unf;

   modport master (
      output stall, branch_en, call_en, ret_en, target,
      input  pc, pc_plus, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
   );

   modport slave (
      input  stall, branch_en, call_en, ret_en, target,
      output pc, pc_plus, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
   );
endinterface

// File: rtl/pc_unit_ras.sv
// Program counter with sequential advance, branch, call/return through a
// circular return-address stack, stall, and sticky overflow/underflow flags.
module pc_unit_ras #(
   parameter int               WIDTH      = 16,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0,
   parameter int               INC        = 1,
   parameter int               RAS_DEPTH  = 4
) (
   input logic           clk,
   input logic           rst_n,
   pc_unit_ras_if.slave  bus
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_SEQ,
      OP_BRANCH,
      OP_CALL,
      OP_RET,
      OP_RET_EMPTY
   } op_e;

   op_e              w_op;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_next;
   logic [WIDTH-1:0] w_pc_plus;
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptr_next;
   logic [PTR_W-1:0] w_ptr_dec;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;
   logic             r_ovf;
   logic             w_ovf_next;
   logic             r_unf;
   logic             w_unf_next;
   logic             w_full;
   logic             w_empty;
   logic [WIDTH-1:0] r_ras_mem [RAS_DEPTH];

   assign w_pc_plus = r_pc + WIDTH'(INC);
   assign w_ptr_dec = r_ptr - PTR_W'(1);
   assign w_full    = (r_count == DEPTH_C);
   assign w_empty   = (r_count == '0);

   // One operation per cycle, chosen strictly by priority.
   always_comb begin
      w_op = OP_SEQ;
      if (bus.stall)          w_op = OP_HOLD;
      else if (bus.ret_en)    w_op = w_empty ? OP_RET_EMPTY : OP_RET;
      else if (bus.call_en)   w_op = OP_CALL;
      else if (bus.branch_en) w_op = OP_BRANCH;
   end

   always_comb begin
      w_pc_next    = r_pc;
      w_ptr_next   = r_ptr;
      w_count_next = r_count;
      w_ovf_next   = r_ovf;
      w_unf_next   = r_unf;
      case (w_op)
         OP_SEQ:       w_pc_next = w_pc_plus;
         OP_BRANCH:    w_pc_next = bus.target;
         OP_CALL: begin
            w_pc_next  = bus.target;
            w_ptr_next = r_ptr + PTR_W'(1);
            if (w_full) w_ovf_next   = 1'b1;
            else        w_count_next = r_count + CNT_W'(1);
         end
         OP_RET: begin
            // Only reached with a valid entry, so no unwritten slot is read.
            w_pc_next    = r_ras_mem[w_ptr_dec];
            w_ptr_next   = w_ptr_dec;
            w_count_next = r_count - CNT_W'(1);
         end
         OP_RET_EMPTY: begin
            w_pc_next  = w_pc_plus;
            w_unf_next = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_ADDR;
         r_ptr   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_pc    <= w_pc_next;
         r_ptr   <= w_ptr_next;
         r_count <= w_count_next;
         r_ovf   <= w_ovf_next;
         r_unf   <= w_unf_next;
      end
   end

   // Stack storage carries no reset; a full stack simply overwrites the oldest slot.
   always_ff @(posedge clk) begin
      if (w_op == OP_CALL) r_ras_mem[r_ptr] <= w_pc_plus;
   end

   assign bus.pc        = r_pc;
   assign bus.pc_plus   = w_pc_plus;
   assign bus.ras_count = r_count;
   assign bus.ras_full  = w_full;
   assign bus.ras_empty = w_empty;
   assign bus.ras_ovf   = r_ovf;
   assign bus.ras_unf   = r_unf;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed vector table, hand-written
// reset sequences, then random traffic against a queue-based stack model.
module tb_pc_unit_ras;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pc_unit_ras_if #(.WIDTH(16), .RAS_DEPTH(4)) bus ();

   pc_unit_ras #(
      .WIDTH(16), .RESET_ADDR(16'h0000), .INC(1), .RAS_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        st, br, ca, re;
      logic [15:0] tgt;
      logic [15:0] pc;
      int          cnt;
      logic        ovf, unf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic st, logic br, logic ca, logic re, logic [15:0] tgt,
                               logic [15:0] pc, int cnt, logic ovf, logic unf);
      vec_t v;
      v.st = st; v.br = br; v.ca = ca; v.re = re; v.tgt = tgt;
      v.pc = pc; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic br, input logic ca, input logic re,
                        input logic [15:0] tgt);
      bus.stall = st; bus.branch_en = br; bus.call_en = ca; bus.ret_en = re; bus.target = tgt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [15:0] epc, input int ecnt,
                            input logic eovf, input logic eunf);
      logic [15:0] eplus;
      eplus = epc + 16'd1;
      chk({tag, ".pc"},      32'(bus.pc),        32'(epc));
      chk({tag, ".pc_plus"}, 32'(bus.pc_plus),   32'(eplus));
      chk({tag, ".count"},   32'(bus.ras_count), 32'(ecnt));
      chk({tag, ".full"},    32'(bus.ras_full),  32'(ecnt == 4));
      chk({tag, ".empty"},   32'(bus.ras_empty), 32'(ecnt == 0));
      chk({tag, ".ovf"},     32'(bus.ras_ovf),   32'(eovf));
      chk({tag, ".unf"},     32'(bus.ras_unf),   32'(eunf));
      $display("%-10s st=%b br=%b ca=%b re=%b tgt=%h -> pc=%h cnt=%0d ovf=%b unf=%b",
               tag, bus.stall, bus.branch_en, bus.call_en, bus.ret_en, bus.target,
               bus.pc, bus.ras_count, bus.ras_ovf, bus.ras_unf);
   endtask

   // Reference model: the stack is a bounded queue, newest entry at the back.
   logic [15:0] m_pc;
   logic [15:0] m_stack[$];
   logic        m_ovf, m_unf;

   task automatic model_step(input logic st, input logic br, input logic ca, input logic re,
                             input logic [15:0] tgt);
      if (st) return;
      if (re) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else begin
            m_pc  = m_pc + 16'd1;
            m_unf = 1'b1;
         end
      end else if (ca) begin
         if (m_stack.size() == 4) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
         end
         m_stack.push_back(m_pc + 16'd1);
         m_pc = tgt;
      end else if (br) m_pc = tgt;
      else m_pc = m_pc + 16'd1;
   endtask

   initial begin
      // Branch, stall and wrap
      vecs.push_back(mk(0, 1, 0, 0, 16'hFFFE, 16'hFFFE, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 16'h1234, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0));
      // Nested call / return
      vecs.push_back(mk(0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0100, 16'h0100, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0200, 16'h0200, 2, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0101, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0011, 0, 0, 0));
      // Overflow then underflow
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0010, 16'h0010, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0020, 16'h0020, 2, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0030, 16'h0030, 3, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0040, 16'h0040, 4, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0050, 16'h0050, 4, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0041, 3, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0031, 2, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0021, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0011, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0012, 0, 1, 1));
      // Priority collisions with 0x0055 on the stack
      vecs.push_back(mk(0, 1, 0, 0, 16'h0054, 16'h0054, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0080, 16'h0080, 1, 1, 1));
      vecs.push_back(mk(0, 1, 1, 1, 16'h0300, 16'h0055, 0, 1, 1));
      vecs.push_back(mk(0, 1, 1, 0, 16'h0300, 16'h0300, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0056, 0, 1, 1));

      drive(0, 0, 0, 0, 16'h0000);
      rst_n = 1'b0;
      repeat (2) tick();
      check_all("reset", 16'h0000, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_all("seq", 16'(i), 0, 0, 0);
      end

      // Reset asserted between edges must clear pc before any edge.
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 16'h0000, 0, 0, 0);
      tick();
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].br, vecs[i].ca, vecs[i].re, vecs[i].tgt);
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
      end

      // Reset with a partly filled stack and sticky flags set.
      for (int i = 1; i <= 3; i++) begin
         drive(0, 0, 1, 0, 16'h0400);
         tick();
         check_all("fill", 16'h0400, i, 1, 1);
      end
      drive(0, 0, 0, 0, 16'h0000);
      rst_n = 1'b0;
      tick();
      check_all("rst_stack", 16'h0000, 0, 0, 0);
      rst_n = 1'b1;
      drive(0, 0, 0, 1, 16'h0000);
      tick();
      check_all("ret_empty", 16'h0001, 0, 0, 1);

      // Randomised traffic against the model.
      drive(0, 0, 0, 0, 16'h0000);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_pc = 16'h0000;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic        st, br, ca, re;
         logic [15:0] tgt;
         st  = ($urandom_range(0, 7) == 0);
         re  = ($urandom_range(0, 3) == 0);
         ca  = ($urandom_range(0, 2) == 0);
         br  = ($urandom_range(0, 2) == 0);
         tgt = 16'($urandom);
         drive(st, br, ca, re, tgt);
         model_step(st, br, ca, re, tgt);
         tick();
         check_all($sformatf("rnd%0d", n), m_pc, m_stack.size(), m_ovf, m_unf);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised program-counter unit, the next generation of the 16-bit PC register.
- Holds the fetch address and advances it sequentially.
- Also handles taken branches, subroutine calls and returns.
- Returns use an internal circular return-address stack (RAS).
- Sits between the control unit's next-PC decision signals and the instruction-memory address port.
- Supports stall, reports stack overflow/underflow, and wraps modulo 2^WIDTH.

Parameters:
- WIDTH, 16, PC/address width in bits.
- RESET_ADDR, 0, PC value loaded on reset (WIDTH bits).
- INC, 1, sequential increment added to PC each advance (1 = word addressing, 2 = byte addressing of 16-bit words).
- RAS_DEPTH, 4, return-stack entries; power of 2, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS unchanged this cycle.
- branch_en  in  1  load PC from target.
- call_en  in  1  push PC+INC onto RAS, load PC from target.
- ret_en  in  1  pop RAS into PC.
- target  in  WIDTH  branch/call destination.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus  out  WIDTH  combinational pc+INC, mod 2^WIDTH.
- ras_count  out  clog2(RAS_DEPTH)+1  valid entries on RAS.
- ras_full  out  1  ras_count==RAS_DEPTH.
- ras_empty  out  1  ras_count==0.
- ras_ovf  out  1  sticky: a call occurred while full.
- ras_unf  out  1  sticky: a return occurred while empty.

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid-operation):
  - pc=RESET_ADDR, ras_count=0, stack pointer=0, ras_ovf=0, ras_unf=0.
  - Stack contents are don't-care.
- All updates occur on the rising clk edge. Latency is 1 cycle: a request presented in cycle N is visible on pc in cycle N+1.
- Priority per cycle: stall > ret_en > call_en > branch_en > sequential. Lower-priority requests asserted in the same cycle are ignored, with no side effects.
- stall=1: pc, RAS, count and flags are all held. Requests are dropped; the control unit re-asserts them.
- Sequential (no request): pc <= pc+INC, truncated to WIDTH. 2^WIDTH-INC+k wraps to k-? no: pc wraps modulo 2^WIDTH, e.g. 0xFFFF → 0x0000 when WIDTH=16, INC=1.
- branch_en: pc <= target. The RAS is untouched.
- call_en:
  - The RAS write and the pc load happen in the same edge.
  - Write pc+INC (wrapped) at the stack pointer; pointer <= pointer+1 mod RAS_DEPTH; pc <= target.
  - If not full: ras_count += 1.
  - If full: the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, and ras_ovf <= 1.
- ret_en:
  - If not empty: pointer <= pointer-1 mod RAS_DEPTH; pc <= entry at (pointer-1); ras_count -= 1.
  - If empty: pc <= pc+INC (behaves as sequential), the pointer is unchanged, and ras_unf <= 1.
- ras_ovf and ras_unf stay set until reset; nothing else clears them.
- ras_full and ras_empty are combinational from ras_count.
- pc_plus tracks pc combinationally.
- No X may propagate to pc from an unwritten RAS entry, because an empty pop never reads the array.

Test Plan:
Defaults for all scenarios: WIDTH=16, INC=1, RAS_DEPTH=4, RESET_ADDR=0.
1. Reset and sequential:
   - Stimulus: hold rst_n=0, then release; run 5 cycles with no requests.
   - Required: pc=0 during reset, then 1,2,3,4,5. ras_empty=1, ras_count=0, flags 0.
   - Also: assert rst_n=0 mid-clock → pc drops to 0 immediately, without waiting for an edge.
2. Branch, stall and wrap:
   - Stimulus: branch_en with target=0xFFFE, then one sequential cycle, then stall for 2 cycles, then sequential.
   - Required: pc=0xFFFE, 0xFFFF, held at 0xFFFF for the 2 stall cycles, then 0x0000.
   - Also: stall with call_en=1 → no push, ras_count unchanged.
3. Call/return nesting:
   - Stimulus: at pc=0x0010 call target=0x0100; at 0x0100 call target=0x0200; then ret, ret.
   - Required: pc sequence 0x0100, 0x0200, 0x0101, 0x0011. ras_count 1, 2, 1, 0.
4. Overflow:
   - Stimulus: 5 consecutive calls from pc=0x0000 to targets 0x10, 0x20, 0x30, 0x40, 0x50; then 5 returns.
   - Required: ras_ovf=1 after the 5th call, ras_count=4.
   - Return pcs: 0x41, 0x31, 0x21, 0x11.
   - The 5th return hits an empty stack: pc=0x12 and ras_unf=1.
5. Priority collision:
   - Stimulus: ret_en, call_en and branch_en all high at once with one entry (0x0055) on the RAS; target=0x0300.
   - Required: pc=0x0055, ras_count=0, no push.
   - Then call_en and branch_en together with target=0x0300 → pc=0x0300 and ras_count=1.
6. Reset with active stack:
   - Stimulus: 3 entries on the RAS and ras_ovf=1, then pulse rst_n=0 for 1 cycle.
   - Required: pc=0, ras_count=0, ras_ovf=0, ras_unf=0.
   - A ret after release → pc=1 and ras_unf=1.
